// File: rtl/snake_game_ctrl.sv
`default_nettype none
// =====================================================================
// snake_game_ctrl - collision check, growth/score and LFSR food placement
// Revision 1.0
// =====================================================================
module snake_game_ctrl #(
   parameter int                 MAX_LEN   = 16,
   parameter int                 NUM_LEN   = 10,
   parameter logic [3:0]         INIT_LEN  = 4'd5,
   parameter logic [NUM_LEN-1:0] INIT_HEAD = 10'd36,
   parameter logic [NUM_LEN-1:0] FOOD_INIT = 10'd40,
   parameter logic [NUM_LEN-1:0] LFSR_SEED = 10'h2A5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       step,
   input  logic [MAX_LEN*NUM_LEN-1:0] next_pos_num,
   input  logic                       should_stop,
   output logic [MAX_LEN*NUM_LEN-1:0] pos_num,
   output logic [3:0]                 len,
   output logic [NUM_LEN-1:0]         food_pos,
   output logic [7:0]                 score,
   output logic                       game_over,
   output logic                       busy
);

   localparam logic [4:0] ROW_LIMIT = 5'd24;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_CHECK = 3'd2,
      S_FOOD  = 3'd3,
      S_SCAN  = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   state_t             state, state_nx;
   logic [NUM_LEN-1:0] head, lfsr, lfsr_nx, cand, scan_seg;
   logic [3:0]         idx;
   logic               self_hit, collide, eat, row_bad, scan_hit, scan_last;

   function automatic logic [MAX_LEN*NUM_LEN-1:0] init_body();
      logic [MAX_LEN*NUM_LEN-1:0] b;
      for (int i = 0; i < MAX_LEN; i++)
         b[i*NUM_LEN +: NUM_LEN] = (i < int'(INIT_LEN)) ? INIT_HEAD - NUM_LEN'(i) : '1;
      return b;
   endfunction

   assign head      = next_pos_num[NUM_LEN-1:0];
   assign lfsr_nx   = {lfsr[NUM_LEN-2:0], lfsr[9] ^ lfsr[6]};
   assign row_bad   = lfsr_nx[NUM_LEN-1:5] >= ROW_LIMIT;
   assign scan_seg  = pos_num[int'(idx)*NUM_LEN +: NUM_LEN];
   assign scan_hit  = (scan_seg == cand);
   assign scan_last = (idx == len - 4'd1);
   assign collide   = should_stop | self_hit;
   assign eat       = (head == food_pos);

   // Slots at or beyond len carry stale tail data and must not count as body.
   always_comb begin
      self_hit = 1'b0;
      for (int k = 1; k < MAX_LEN; k++)
         if ((4'(k) < len) && (next_pos_num[k*NUM_LEN +: NUM_LEN] == head))
            self_hit = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (step)  state_nx = S_CHECK;
         S_CHECK: begin
            if (collide)  state_nx = S_OVER;
            else if (eat) state_nx = S_FOOD;
            else          state_nx = S_RUN;
         end
         S_FOOD:  if (!row_bad) state_nx = S_SCAN;
         S_SCAN: begin
            if (scan_hit)       state_nx = S_FOOD;
            else if (scan_last) state_nx = S_RUN;
         end
         S_OVER:  if (start) state_nx = S_RUN;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_num   <= init_body();
         len       <= INIT_LEN;
         food_pos  <= FOOD_INIT;
         score     <= 8'd0;
         lfsr      <= LFSR_SEED;
         cand      <= '0;
         idx       <= 4'd0;
         game_over <= 1'b0;
         busy      <= 1'b0;
      end else begin
         game_over <= (state_nx == S_OVER);
         busy      <= (state_nx == S_CHECK) || (state_nx == S_FOOD) || (state_nx == S_SCAN);
         unique case (state)
            S_CHECK: begin
               if (!collide) begin
                  pos_num <= next_pos_num;
                  if (eat) begin
                     if (len != 4'hF)    len   <= len + 4'd1;
                     if (score != 8'hFF) score <= score + 8'd1;
                  end
               end
            end
            S_FOOD: begin
               lfsr <= lfsr_nx;
               cand <= lfsr_nx;
               idx  <= 4'd0;
            end
            S_SCAN: begin
               if (!scan_hit && scan_last) food_pos <= cand;
               idx <= idx + 4'd1;
            end
            S_OVER: begin
               // Restart keeps the LFSR running so each game gets new food.
               if (start) begin
                  pos_num  <= init_body();
                  len      <= INIT_LEN;
                  food_pos <= FOOD_INIT;
                  score    <= 8'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// tb_snake_game_ctrl - bench with a game-level reference model
// Revision 1.0
// =====================================================================
module tb_snake_game_ctrl;

   logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, step = 1'b0;
   logic [159:0] next_pos_num;
   logic         should_stop;
   logic [159:0] pos_num;
   logic [3:0]   len;
   logic [9:0]   food_pos;
   logic [7:0]   score;
   logic         game_over, busy;

   int checks = 0, errors = 0;

   snake_game_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .step(step),
      .next_pos_num(next_pos_num), .should_stop(should_stop),
      .pos_num(pos_num), .len(len), .food_pos(food_pos), .score(score),
      .game_over(game_over), .busy(busy)
   );

   always #5 clk = ~clk;

   // Game-level model: mode flags, body, and a countdown of food-placement cycles.
   logic [159:0] m_pos;
   int           m_len, m_food, m_score, m_busy_left, m_pend;
   bit           m_run, m_over, m_chk;
   logic [9:0]   m_lfsr;
   bit           ovr_en = 1'b0, chk_en = 1'b0;
   logic [159:0] ovr_pos = '0;

   function automatic logic [159:0] reset_body();
      logic [159:0] b;
      for (int i = 0; i < 16; i++) b[i*10 +: 10] = (i < 5) ? 10'(36 - i) : 10'h3FF;
      return b;
   endfunction

   function automatic logic [159:0] pat(input logic [9:0] hd, input int dup, input int base);
      logic [159:0] b;
      for (int i = 0; i < 16; i++) b[i*10 +: 10] = 10'(base + i);
      b[9:0] = hd;
      if (dup > 0) b[dup*10 +: 10] = hd;
      return b;
   endfunction

   // Whole food search at once: returns cycle count, food cell and final LFSR.
   function automatic void place(input logic [159:0] p, input int l, input logic [9:0] lf_in,
                                 output logic [9:0] lf_out, output int n, output int food);
      logic [9:0] lf;
      int hit;
      lf = lf_in; n = 0; food = 0;
      for (int tries = 0; tries < 4000; tries++) begin
         lf = {lf[8:0], lf[9] ^ lf[6]};
         n++;
         if (lf[9:5] < 5'd24) begin
            hit = -1;
            for (int k = 0; k < l; k++) if (hit < 0 && p[k*10 +: 10] == lf) hit = k;
            if (hit < 0) begin
               n += l; food = int'(lf); lf_out = lf;
               return;
            end
            n += hit + 1;
         end
      end
      lf_out = lf;
   endfunction

   // Wall-following-right mover, or a forced candidate body.
   always_comb begin
      if (ovr_en) begin
         next_pos_num = ovr_pos;
         should_stop  = 1'b0;
      end else begin
         next_pos_num = {m_pos[149:0], m_pos[9:0] + 10'd1};
         should_stop  = (m_pos[4:0] == 5'd31);
      end
   end

   always @(posedge clk or negedge rst_n) begin : model
      logic [159:0] p;
      int           l, f, s, bl, fp, n, nf;
      bit           rn, ov, ck, hit;
      logic [9:0]   lf, lf2, hd;
      if (!rst_n) begin
         m_pos <= reset_body(); m_len <= 5; m_food <= 40; m_score <= 0;
         m_lfsr <= 10'h2A5; m_busy_left <= 0; m_pend <= 0;
         m_run <= 1'b0; m_over <= 1'b0; m_chk <= 1'b0;
      end else begin
         p = m_pos; l = m_len; f = m_food; s = m_score; bl = m_busy_left; fp = m_pend;
         rn = m_run; ov = m_over; ck = m_chk; lf = m_lfsr;
         if (ck) begin
            ck  = 1'b0;
            hd  = next_pos_num[9:0];
            hit = should_stop;
            for (int k = 1; k < l; k++) if (next_pos_num[k*10 +: 10] == hd) hit = 1'b1;
            if (hit) ov = 1'b1;
            else begin
               p = next_pos_num;
               if (int'(hd) == f) begin
                  if (l < 15) l++;
                  if (s < 255) s++;
                  place(p, l, lf, lf2, n, nf);
                  lf = lf2; bl = n; fp = nf;
               end
            end
         end else if (bl > 0) begin
            bl--;
            if (bl == 0) f = fp;
         end else if (ov) begin
            if (start) begin p = reset_body(); l = 5; s = 0; f = 40; ov = 1'b0; end
         end else if (!rn) begin
            if (start) rn = 1'b1;
         end else if (step) begin
            ck = 1'b1;
         end
         m_pos <= p; m_len <= l; m_food <= f; m_score <= s; m_busy_left <= bl;
         m_pend <= fp; m_run <= rn; m_over <= ov; m_chk <= ck; m_lfsr <= lf;
      end
   end

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pos_num",   pos_num,          m_pos);
         chk("len",       160'(len),        160'(m_len));
         chk("food_pos",  160'(food_pos),   160'(m_food));
         chk("score",     160'(score),      160'(m_score));
         chk("game_over", 160'(game_over),  160'(m_over));
         chk("busy",      160'(busy),       160'(m_chk || m_busy_left > 0));
      end
   end

   // One tick; returns how many cycles busy stayed high afterwards.
   task automatic do_step(output int t);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      t = 0;
      while (busy && t < 200) begin t++; @(negedge clk); end
      if (t >= 200) begin
         checks++; errors++;
         $display("FAIL step_timeout: busy still %b after %0d cycles", busy, t);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin : stim
      int           t, g;
      logic [159:0] wall;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      chk("rst_body",  pos_num,            reset_body());
      chk("rst_len",   160'(len),          160'(5));
      chk("rst_food",  160'(food_pos),     160'(40));
      chk("rst_score", 160'(score),        160'(0));
      chk("rst_over",  160'(game_over),    160'(0));
      chk("rst_busy",  160'(busy),         160'(0));

      step = 1'b1; @(negedge clk); step = 1'b0; @(negedge clk);
      chk("idle_step_dropped", 160'(pos_num[9:0]), 160'(36));
      start = 1'b1; step = 1'b1; @(negedge clk); start = 1'b0; step = 1'b0;
      @(negedge clk);
      chk("start_wins_head", 160'(pos_num[9:0]), 160'(36));
      chk("start_wins_busy", 160'(busy),         160'(0));

      for (int i = 1; i <= 3; i++) begin
         do_step(t);
         chk("move_head", 160'(pos_num[9:0]), 160'(36 + i));
         chk("move_len",  160'(len),          160'(5));
         chk("move_busy_cycles", 160'(t),     160'(1));
      end
      do_step(t);
      chk("eat_head",   160'(pos_num[9:0]), 160'(40));
      chk("eat_len",    160'(len),          160'(6));
      chk("eat_score",  160'(score),        160'(1));
      chk("eat_food",   160'(food_pos),     160'(10'h14B));
      chk("eat_busy_cycles", 160'(t),       160'(8));
      chk("food_row_ok", 160'(food_pos[9:5] < 5'd24), 160'(1));
      for (int k = 0; k < 6; k++)
         chk("food_not_on_body", 160'(food_pos != pos_num[k*10 +: 10]), 160'(1));

      g = 0;
      while (pos_num[4:0] != 5'd31 && g < 40) begin do_step(t); g++; end
      for (int i = 0; i < 16; i++) wall[i*10 +: 10] = 10'(63 - i);
      chk("wall_approach", pos_num, wall);
      do_step(t);
      chk("wall_over", 160'(game_over), 160'(1));
      chk("wall_body_kept", pos_num, wall);
      do_step(t);
      do_step(t);
      chk("over_step_dropped", pos_num, wall);
      chk("over_still", 160'(game_over), 160'(1));
      pulse_start();
      chk("restart_body",  pos_num,         reset_body());
      chk("restart_over",  160'(game_over), 160'(0));
      chk("restart_food",  160'(food_pos),  160'(40));
      chk("restart_score", 160'(score),     160'(0));

      ovr_pos = pat(10'd100, 3, 200); ovr_en = 1'b1;
      do_step(t);
      chk("self_hit_over", 160'(game_over), 160'(1));
      chk("self_hit_kept", pos_num, reset_body());
      pulse_start();
      ovr_pos = pat(10'd100, 6, 200);
      do_step(t);
      chk("beyond_len_commit", pos_num, pat(10'd100, 6, 200));
      chk("beyond_len_run",    160'(game_over), 160'(0));

      ovr_pos = pat(10'd40, 0, 300);
      step = 1'b1;
      g = 0;
      do begin @(negedge clk); g++; end while (busy && g < 200);
      step = 1'b0;
      repeat (2) @(negedge clk);
      chk("flood_score", 160'(score), 160'(1));
      chk("flood_len",   160'(len),   160'(6));
      chk("flood_busy",  160'(busy),  160'(0));

      ovr_pos = pat(10'(m_food), 0, m_food + 1);
      step = 1'b1; @(negedge clk); step = 1'b0;
      repeat (2) @(negedge clk);
      chk("busy_before_reset", 160'(busy), 160'(1));
      #3 rst_n = 1'b0;
      @(negedge clk);
      chk("abort_body",  pos_num,         reset_body());
      chk("abort_len",   160'(len),       160'(5));
      chk("abort_food",  160'(food_pos),  160'(40));
      chk("abort_score", 160'(score),     160'(0));
      chk("abort_busy",  160'(busy),      160'(0));
      rst_n = 1'b1; ovr_en = 1'b0;
      @(negedge clk);
      pulse_start();
      do_step(t);
      chk("post_reset_move", 160'(pos_num[9:0]), 160'(37));

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
